// File: rtl/line_buffer_reader.sv
`default_nettype none
// ============================================================================
// line_buffer_reader : streams one line of pixels out of the line buffer
//                      read port onto a valid/ready stream with a last flag.
// Revision: 1.0
// ============================================================================
module line_buffer_reader #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   line_len,
   output logic [ADDR_W-1:0] adb,
   output logic              ceb,
   output logic              oce,
   output logic              resetb,
   input  logic [DATA_W-1:0] dout,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic              pix_last,
   output logic              busy,
   output logic              done
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [ADDR_W:0]  LEN_ONE   = 1;
   localparam logic [PTR_W-1:0] PTR_ONE   = 1;
   localparam logic [CNT_W-1:0] CNT_ONE   = 1;
   localparam logic [CNT_W:0]   CNT_DEPTH = FIFO_DEPTH;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic [ADDR_W:0]     issue_cnt_q, issue_cnt_d;
   logic [ADDR_W:0]     acc_cnt_q, acc_cnt_d;
   logic                ceb_q, ceb_d;
   logic [ADDR_W-1:0]   adb_q, adb_d;
   logic [1:0]          infl_q, infl_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                push;
   logic                pop;
   logic [CNT_W:0]      outstanding;
   logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];

   always_comb begin
      pop  = (count_q != '0) && pix_ready;
      push = infl_q[1];

      count_d = count_q;
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!push && pop) begin
         count_d = count_q - CNT_ONE;
      end
      wr_ptr_d    = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d    = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      infl_d      = {infl_q[0], ceb_q};
      acc_cnt_d   = pop   ? (acc_cnt_q + LEN_ONE)   : acc_cnt_q;
      issue_cnt_d = ceb_q ? (issue_cnt_q + LEN_ONE) : issue_cnt_q;

      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      done_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The done cycle is still IDLE; a start there must not be taken.
            if (start && !done_q) begin
               base_d      = base_addr;
               len_d       = line_len;
               issue_cnt_d = '0;
               acc_cnt_d   = '0;
               state_d     = (line_len == '0) ? ST_DRAIN : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (ceb_q && (issue_cnt_q == (len_q - LEN_ONE))) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_DRAIN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Drain completion is judged on next-state values so done lands in the
      // cycle right after the final pixel transfers.
      if ((state_d == ST_DRAIN) && (acc_cnt_d == len_d) && (count_d == '0)) begin
         state_d = ST_IDLE;
         done_d  = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);

      // Credit covers FIFO occupancy plus every read still in the pipeline.
      outstanding = {1'b0, count_d} + {{CNT_W{1'b0}}, infl_d[0]}
                                    + {{CNT_W{1'b0}}, infl_d[1]};
      ceb_d = (state_d == ST_ISSUE) && (outstanding < CNT_DEPTH);
      adb_d = base_d + issue_cnt_d[ADDR_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         base_q      <= '0;
         len_q       <= '0;
         issue_cnt_q <= '0;
         acc_cnt_q   <= '0;
         ceb_q       <= 1'b0;
         adb_q       <= '0;
         infl_q      <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         len_q       <= len_d;
         issue_cnt_q <= issue_cnt_d;
         acc_cnt_q   <= acc_cnt_d;
         ceb_q       <= ceb_d;
         adb_q       <= adb_d;
         infl_q      <= infl_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= dout;
      end
   end

   assign adb       = adb_q;
   assign ceb       = ceb_q;
   assign oce       = 1'b1;
   assign resetb    = reset;
   assign pix_data  = fifo_mem[rd_ptr_q];
   assign pix_valid = (count_q != '0);
   assign pix_last  = pix_valid && (acc_cnt_q == (len_q - LEN_ONE));
   assign busy      = busy_q;
   assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_line_buffer_reader.sv
`default_nettype none
// ============================================================================
// tb_line_buffer_reader : directed self-checking bench with a 2-cycle BRAM model.
// Revision: 1.0
// ============================================================================
module tb_line_buffer_reader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [10:0] base_addr;
   logic [11:0] line_len;
   logic [10:0] adb;
   logic        ceb;
   logic        oce;
   logic        resetb;
   logic [15:0] dout;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;
   logic        busy;
   logic        done;

   line_buffer_reader #(.ADDR_W(11), .DATA_W(16), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
      .line_len(line_len), .adb(adb), .ceb(ceb), .oce(oce), .resetb(resetb),
      .dout(dout), .pix_data(pix_data), .pix_valid(pix_valid),
      .pix_ready(pix_ready), .pix_last(pix_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   logic [15:0] bram [2048];
   logic [15:0] bram_r1;
   logic [15:0] bram_out;
   initial begin
      for (int i = 0; i < 2048; i++) bram[i] = 16'hA000 + 16'(i);
      bram_r1  = '0;
      bram_out = '0;
   end
   always @(posedge clk) begin
      if (ceb) bram_r1 <= bram[adb];
      if (oce) bram_out <= bram_r1;
   end
   assign dout = bram_out;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          t0 = 0;
   logic [15:0] x_data [$];
   logic        x_last [$];
   int          x_cyc  [$];
   logic [10:0] a_log  [$];
   int          d_cyc  [$];
   int          issued = 0;
   int          accepted = 0;
   int          max_out = 0;

   always @(negedge clk) begin
      if (ceb) begin
         a_log.push_back(adb);
         issued = issued + 1;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      if (pix_valid && pix_ready) begin
         x_data.push_back(pix_data);
         x_last.push_back(pix_last);
         x_cyc.push_back(cyc - t0);
         accepted = accepted + 1;
      end
      if (done) d_cyc.push_back(cyc - t0);
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      x_data.delete();
      x_last.delete();
      x_cyc.delete();
      a_log.delete();
      d_cyc.delete();
      issued   = 0;
      accepted = 0;
      max_out  = 0;
   endtask

   task automatic launch(input logic [10:0] b, input logic [11:0] l);
      clear_logs();
      base_addr = b;
      line_len  = l;
      start     = 1'b1;
      t0        = cyc;
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin
         tick();
         k++;
      end
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_ceb"},   32'(ceb),       32'd0);
      check({tag, "_adb"},   32'(adb),       32'd0);
      check({tag, "_valid"}, 32'(pix_valid), 32'd0);
      check({tag, "_last"},  32'(pix_last),  32'd0);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_done"},  32'(done),      32'd0);
   endtask

   initial begin
      int nlast;
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      line_len  = '0;
      pix_ready = 1'b1;
      tick();
      tick();
      check("rst_resetb", 32'(resetb), 32'd1);
      check("rst_oce",    32'(oce),    32'd1);
      check_outputs_reset("rst");
      reset = 1'b0;
      tick();

      // Basic line: base 0, len 8, ready high.
      launch(11'd0, 12'd8);
      check("basic_c1_busy", 32'(busy), 32'd1);
      check("basic_c1_ceb",  32'(ceb),  32'd1);
      check("basic_c1_adb",  32'(adb),  32'd0);
      wait_done(100);
      check("basic_done_cyc", 32'(cyc - t0), 32'd12);
      check("basic_done_busy", 32'(busy), 32'd0);
      check("basic_count", 32'(x_data.size()), 32'd8);
      nlast = 0;
      for (int i = 0; i < x_data.size() && i < 8; i++) begin
         check($sformatf("basic_data%0d", i), 32'(x_data[i]), 32'hA000 + 32'(i));
         check($sformatf("basic_cyc%0d", i),  32'(x_cyc[i]),  32'd4 + 32'(i));
         if (x_last[i]) nlast++;
      end
      check("basic_last_cnt", 32'(nlast), 32'd1);
      if (x_last.size() == 8) check("basic_last7", 32'(x_last[7]), 32'd1);

      // Start coinciding with done must be ignored.
      base_addr = 11'd0;
      line_len  = 12'd2;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      check("startdone_busy", 32'(busy), 32'd0);
      check("startdone_ceb",  32'(ceb),  32'd0);
      tick();
      tick();

      // Address wrap within a line.
      launch(11'd2045, 12'd6);
      wait_done(100);
      check("wrap_count", 32'(a_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < a_log.size() && i < x_data.size(); i++) begin
         check($sformatf("wrap_adb%0d", i),  32'(a_log[i]),
               32'((11'd2045 + 11'(i)) & 11'h7FF));
         check($sformatf("wrap_data%0d", i), 32'(x_data[i]),
               32'hA000 + 32'((11'd2045 + 11'(i)) & 11'h7FF));
      end
      tick();

      // Backpressure: 20 low cycles, then pseudo-random ready.
      pix_ready = 1'b0;
      launch(11'd300, 12'd32);
      for (int k = 0; k < 600 && !done; k++) begin
         pix_ready = (k < 19) ? 1'b0 : 1'($urandom_range(0, 1));
         tick();
      end
      if (!done) check("bp_done_timeout", 32'd0, 32'd1);
      pix_ready = 1'b1;
      check("bp_count",   32'(x_data.size()), 32'd32);
      check("bp_ceb_cnt", 32'(a_log.size()),  32'd32);
      check("bp_max_out", 32'(max_out),       32'd4);
      nlast = 0;
      for (int i = 0; i < x_data.size() && i < 32; i++) begin
         check($sformatf("bp_data%0d", i), 32'(x_data[i]), 32'hA000 + 32'd300 + 32'(i));
         if (x_last[i]) nlast++;
      end
      check("bp_last_cnt", 32'(nlast), 32'd1);
      if (x_last.size() == 32) check("bp_last31", 32'(x_last[31]), 32'd1);
      tick();

      // Zero-length line.
      launch(11'd5, 12'd0);
      check("zero_done_c1", 32'(done), 32'd1);
      tick();
      tick();
      tick();
      check("zero_ceb_cnt",  32'(a_log.size()),  32'd0);
      check("zero_pix_cnt",  32'(x_data.size()), 32'd0);
      check("zero_done_cnt", 32'(d_cyc.size()),  32'd1);
      if (d_cyc.size() > 0) check("zero_done_cyc", 32'(d_cyc[0]), 32'd1);

      // Reset in the middle of a line (pixel 5 transfers in cycle 9).
      launch(11'd0, 12'd16);
      while (cyc - t0 < 9) tick();
      reset = 1'b1;
      tick();
      check_outputs_reset("midrst");
      reset = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("midrst_no_done", 32'(d_cyc.size()), 32'd0);
      launch(11'd100, 12'd4);
      wait_done(100);
      check("rst_new_count", 32'(x_data.size()), 32'd4);
      for (int i = 0; i < 4 && i < x_data.size(); i++)
         check($sformatf("rst_new_data%0d", i), 32'(x_data[i]), 32'hA000 + 32'd100 + 32'(i));
      tick();

      // A start during a line is ignored.
      launch(11'd10, 12'd6);
      tick();
      tick();
      base_addr = 11'd500;
      line_len  = 12'd3;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      wait_done(100);
      check("busy_start_done_cyc", 32'(cyc - t0), 32'd10);
      check("busy_start_count", 32'(x_data.size()), 32'd6);
      for (int i = 0; i < 6 && i < x_data.size(); i++)
         check($sformatf("busy_start_data%0d", i), 32'(x_data[i]), 32'hA000 + 32'd10 + 32'(i));
      tick();
      tick();
      check("busy_start_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/line_buffer_reader.md
# line_buffer_reader

Read-side controller for the 2K×16 simple dual-port line buffer between the OV7670 capture path and the display path. On a start request it streams `line_len` consecutive 16-bit pixels starting at `base_addr` out of the buffer's read port. It absorbs the buffer's two-cycle registered-output latency and presents the pixels on a valid/ready stream with a last-pixel flag. The writer (capture side) owns port A; this block owns port B only.

## Interface
Parameters:
- `ADDR_W`, 11, buffer address width (2048 words)
- `DATA_W`, 16, pixel width (RGB565)
- `FIFO_DEPTH`, 4, output skid FIFO entries (power of two, ≥3)

Ports:
- `clk`  in  1  single clock; also drives buffer `clkb`
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to read a line; ignored while `busy`=1
- `base_addr`  in  ADDR_W  first word address, sampled with `start`
- `line_len`  in  ADDR_W+1  pixel count (0…2048), sampled with `start`
- `adb`  out  ADDR_W  buffer read address
- `ceb`  out  1  buffer read clock enable
- `oce`  out  1  buffer output register enable, constant 1
- `resetb`  out  1  buffer read-port reset, equals `reset`
- `dout`  in  DATA_W  buffer read data, valid 2 cycles after the `ceb` cycle
- `pix_data`  out  DATA_W  stream data
- `pix_valid`  out  1  stream valid
- `pix_ready`  in  1  stream ready from display side
- `pix_last`  out  1  qualifies the final pixel of the line
- `busy`  out  1  line in progress
- `done`  out  1  one-cycle pulse after the final pixel is accepted

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: `start`=1 latches `base_addr`, `line_len`, and clears issue/accept counters. Next state is ISSUE, or DRAIN if `line_len`=0.
- ISSUE: drive `ceb`=1 with `adb` = (base + issue_cnt) mod 2048 when credit is available, i.e. FIFO count + in-flight reads < FIFO_DEPTH. Otherwise drive `ceb`=0. Increment issue_cnt on every issued read. Move to DRAIN after the read with issue_cnt = line_len−1 is issued.
- DRAIN: no reads issued. Return to IDLE once accept_cnt = line_len and the FIFO is empty, pulsing `done` in that same transition.
- In-flight tracking is a 2-stage valid shift register fed by `ceb`. Stage 2 is set during the cycle `dout` holds the data, and `dout` is written into the FIFO at the end of that cycle. `oce` is tied to 1.
- Stream: `pix_valid` = FIFO not empty; `pix_data` = FIFO head. A pixel transfers on `pix_valid & pix_ready`.
- `pix_last` = `pix_valid` and head is pixel index line_len−1.
- Address wraps from 2047 to 0 within a line (ring-buffer use by the writer).
- `line_len`=0 produces no reads and no pixels; `done` is asserted one cycle after `start`.
- Reset values: `ceb`=0, `adb`=0, `pix_valid`=0, `pix_last`=0, `busy`=0, `done`=0, FIFO empty, in-flight register clear, state IDLE.
- Reset mid-line: abandons the line, discards in-flight data, emits no `done`.
- The FIFO never overflows by construction; credit checking includes in-flight reads.
- A simultaneous FIFO push and pop keeps the count unchanged.

## Timing
- `start` in cycle 0 → `busy`=1 from cycle 1 → first `ceb`=1 in cycle 1 with `adb`=base.
- Read issued in cycle n → `dout` valid in cycle n+2 → `pix_valid` from cycle n+3.
- With `pix_ready` held high: one pixel per cycle. The first pixel transfers in cycle 4, and pixel k transfers in cycle 4+k.
- Last pixel (`pix_last`=1) transfers in cycle N+3. `done`=1 in cycle N+4, when `busy` also drops to 0.
- A `start` in the same cycle as `done` is ignored; the earliest accepted restart is the cycle after `done`.
- With `pix_ready`=0, at most FIFO_DEPTH reads are outstanding. `ceb` resumes the cycle after a pop frees a credit.

## Test plan
- Basic line: preload addr i = 16'hA000+i. Pulse `start` with base=0, len=8 and ready=1 → pixels A000…A007 in cycles 4…11, `pix_last` only on A007, `done` in cycle 12.
- Wrap: base=2045, len=6 → `adb` sequence 2045, 2046, 2047, 0, 1, 2; data order matches.
- Backpressure: len=32 with `pix_ready` toggled randomly (including 20 low cycles) → all 32 pixels delivered in order, no duplicates or drops, `ceb` low while credits are exhausted, no FIFO overflow.
- Zero length: len=0 → no `ceb`, no `pix_valid`, `done` in cycle 1.
- Reset mid-line: `reset` asserted at pixel 5 of 16 → all outputs return to reset values the next cycle and no `done` is emitted. A new start with base=100, len=4 then delivers words 100…103 correctly.
- Start while busy: a second `start` during a line is ignored, and the line completes with its original parameters.
